// File: rtl/turn_scheduler.sv
// Connect-4 turn sequencer: latches keypad selections, issues moves to the board over a
// req/done handshake, runs the per-turn forfeit timer and pulses the score counter.
//
// state     | meaning
// SELECT    | current player picks a column; turn timer runs
// ISSUE     | move_req held high until the board answers with move_done
// GAME_OVER | win or draw reached; only new_game is honoured
module turn_scheduler #(
  parameter int COLS          = 7,
  parameter int TIMEOUT_TICKS = 1500,
  parameter int TW            = 11
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          tick_en,
  input  logic          key_valid,
  input  logic [3:0]    key_code,
  input  logic          key_pop,
  input  logic          submit,
  input  logic          new_game,
  output logic          move_req,
  output logic [2:0]    move_col,
  output logic          move_pop,
  output logic          move_player,
  input  logic          move_done,
  input  logic          move_ok,
  input  logic          win,
  input  logic          win_player,
  input  logic          draw,
  output logic          turn,
  output logic          sel_valid,
  output logic [2:0]    sel_col,
  output logic          sel_pop,
  output logic [TW-1:0] time_left,
  output logic          illegal,
  output logic          timeout,
  output logic          score_p1,
  output logic          score_p2,
  output logic          game_over
);

  localparam logic [TW-1:0] RELOAD   = TW'(TIMEOUT_TICKS);
  localparam logic [3:0]    MAX_CODE = 4'(COLS);
  localparam bit            TIMER_ON = (TIMEOUT_TICKS != 0);

  typedef enum logic [1:0] {SELECT, ISSUE, GAME_OVER} state_t;

  state_t state;
  logic   start_player;
  logic   ng_pend;
  logic   key_ok;

  assign key_ok = key_valid && (key_code >= 4'd1) && (key_code <= MAX_CODE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= SELECT;
      turn         <= 1'b0;
      start_player <= 1'b0;
      sel_valid    <= 1'b0;
      sel_col      <= 3'd0;
      sel_pop      <= 1'b0;
      time_left    <= RELOAD;
      ng_pend      <= 1'b0;
      move_req     <= 1'b0;
      move_col     <= 3'd0;
      move_pop     <= 1'b0;
      move_player  <= 1'b0;
      illegal      <= 1'b0;
      timeout      <= 1'b0;
      score_p1     <= 1'b0;
      score_p2     <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      illegal  <= 1'b0;
      timeout  <= 1'b0;
      score_p1 <= 1'b0;
      score_p2 <= 1'b0;
      case (state)
        SELECT, GAME_OVER: begin
          // A pending request from ISSUE lands here, one cycle after its score pulse.
          if (new_game || ng_pend) begin
            start_player <= ~start_player;
            turn         <= ~start_player;
            sel_valid    <= 1'b0;
            sel_col      <= 3'd0;
            sel_pop      <= 1'b0;
            time_left    <= RELOAD;
            ng_pend      <= 1'b0;
            game_over    <= 1'b0;
            state        <= SELECT;
          end else if (state == SELECT) begin
            if (submit && sel_valid) begin
              state       <= ISSUE;
              move_req    <= 1'b1;
              move_col    <= sel_col;
              move_pop    <= sel_pop;
              move_player <= turn;
            end else begin
              if (key_ok) begin
                sel_col   <= 3'(key_code - 4'd1);
                sel_pop   <= key_pop;
                sel_valid <= 1'b1;
              end
              // Forfeit clears any selection made in the same cycle.
              if (TIMER_ON && tick_en) begin
                if (time_left == TW'(1)) begin
                  timeout   <= 1'b1;
                  turn      <= ~turn;
                  sel_valid <= 1'b0;
                  time_left <= RELOAD;
                end else begin
                  time_left <= time_left - TW'(1);
                end
              end
            end
          end
        end
        ISSUE: begin
          if (new_game) ng_pend <= 1'b1;
          if (move_done) begin
            move_req  <= 1'b0;
            sel_valid <= 1'b0;
            if (!move_ok) begin
              illegal <= 1'b1;
              state   <= SELECT;
            end else if (win) begin
              score_p1  <= ~win_player;
              score_p2  <= win_player;
              game_over <= 1'b1;
              state     <= GAME_OVER;
            end else if (draw) begin
              game_over <= 1'b1;
              state     <= GAME_OVER;
            end else begin
              turn      <= ~turn;
              time_left <= RELOAD;
              state     <= SELECT;
            end
          end
        end
        default: state <= SELECT;
      endcase
    end
  end

endmodule

// File: tb/tb_turn_scheduler.sv
// Table-driven bench for turn_scheduler with a short turn timer (4 ticks) so forfeits are reachable.
module tb_turn_scheduler;

  localparam int TO = 4;
  localparam int TW = 11;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          tick_en, key_valid, key_pop, submit, new_game;
  logic [3:0]    key_code;
  logic          move_req, move_pop, move_player;
  logic [2:0]    move_col;
  logic          move_done, move_ok, win, win_player, draw;
  logic          turn, sel_valid, sel_pop;
  logic [2:0]    sel_col;
  logic [TW-1:0] time_left;
  logic          illegal, timeout, score_p1, score_p2, game_over;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  turn_scheduler #(.COLS(7), .TIMEOUT_TICKS(TO), .TW(TW)) dut (
    .clk(clk), .reset_n(reset_n), .tick_en(tick_en),
    .key_valid(key_valid), .key_code(key_code), .key_pop(key_pop),
    .submit(submit), .new_game(new_game),
    .move_req(move_req), .move_col(move_col), .move_pop(move_pop), .move_player(move_player),
    .move_done(move_done), .move_ok(move_ok), .win(win), .win_player(win_player), .draw(draw),
    .turn(turn), .sel_valid(sel_valid), .sel_col(sel_col), .sel_pop(sel_pop),
    .time_left(time_left), .illegal(illegal), .timeout(timeout),
    .score_p1(score_p1), .score_p2(score_p2), .game_over(game_over)
  );

  typedef struct packed {
    logic          req;
    logic [2:0]    col;
    logic          pop;
    logic          pl;
    logic          trn;
    logic          sv;
    logic [TW-1:0] tl;
    logic          ill;
    logic          to;
    logic          s1;
    logic          s2;
    logic          go;
  } exp_t;

  typedef struct {
    logic       kv;
    logic [3:0] kc;
    logic       kp, sub, ng, tk, md, ok, w, wp, dr;
    exp_t       e;
  } vec_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  task automatic add(input logic kv, input logic [3:0] kc,
                     input logic kp, sub, ng, tk, md, ok, w, wp, dr,
                     input logic req, input logic [2:0] col, input logic pop, pl, trn, sv,
                     input int tl, input logic ill, to, s1, s2, go);
    vec_t v;
    v.kv = kv; v.kc = kc; v.kp = kp; v.sub = sub; v.ng = ng; v.tk = tk;
    v.md = md; v.ok = ok; v.w = w; v.wp = wp; v.dr = dr;
    v.e = '{req: req, col: col, pop: pop, pl: pl, trn: trn, sv: sv, tl: TW'(tl),
            ill: ill, to: to, s1: s1, s2: s2, go: go};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic idle_inputs();
    tick_en = 0; key_valid = 0; key_code = 0; key_pop = 0; submit = 0; new_game = 0;
    move_done = 0; move_ok = 0; win = 0; win_player = 0; draw = 0;
  endtask

  task automatic compare_outputs(input string tag, input exp_t e);
    chk({tag, " move_req"},    32'(move_req),    32'(e.req));
    chk({tag, " move_col"},    32'(move_col),    32'(e.col));
    chk({tag, " move_pop"},    32'(move_pop),    32'(e.pop));
    chk({tag, " move_player"}, 32'(move_player), 32'(e.pl));
    chk({tag, " turn"},        32'(turn),        32'(e.trn));
    chk({tag, " sel_valid"},   32'(sel_valid),   32'(e.sv));
    chk({tag, " time_left"},   32'(time_left),   32'(e.tl));
    chk({tag, " illegal"},     32'(illegal),     32'(e.ill));
    chk({tag, " timeout"},     32'(timeout),     32'(e.to));
    chk({tag, " score_p1"},    32'(score_p1),    32'(e.s1));
    chk({tag, " score_p2"},    32'(score_p2),    32'(e.s2));
    chk({tag, " game_over"},   32'(game_over),   32'(e.go));
  endtask

  initial begin
    exp_t e;
    int   waited;

    // kv kc kp sub ng tk md ok w wp dr | req col pop pl turn sv tl ill to s1 s2 go
    add(1,3,0, 0,0,0, 0,0,0,0,0,  0,0,0,0, 0,1,4, 0,0,0,0,0);
    add(0,0,0, 1,0,0, 0,0,0,0,0,  1,2,0,0, 0,1,4, 0,0,0,0,0);
    add(1,5,0, 0,0,1, 0,0,0,0,0,  1,2,0,0, 0,1,4, 0,0,0,0,0);
    add(0,0,0, 0,0,0, 1,1,0,0,0,  0,2,0,0, 1,0,4, 0,0,0,0,0);
    add(1,0,0, 0,0,0, 0,0,0,0,0,  0,2,0,0, 1,0,4, 0,0,0,0,0);
    add(1,8,0, 0,0,0, 0,0,0,0,0,  0,2,0,0, 1,0,4, 0,0,0,0,0);
    add(1,15,0,0,0,0, 0,0,0,0,0,  0,2,0,0, 1,0,4, 0,0,0,0,0);
    add(0,0,0, 1,0,0, 0,0,0,0,0,  0,2,0,0, 1,0,4, 0,0,0,0,0);
    add(1,7,1, 0,0,1, 0,0,0,0,0,  0,2,0,0, 1,1,3, 0,0,0,0,0);
    add(0,0,0, 1,0,0, 0,0,0,0,0,  1,6,1,1, 1,1,3, 0,0,0,0,0);
    add(0,0,0, 0,0,0, 1,0,0,0,0,  0,6,1,1, 1,0,3, 1,0,0,0,0);
    add(0,0,0, 0,0,0, 0,0,0,0,0,  0,6,1,1, 1,0,3, 0,0,0,0,0);
    add(0,0,0, 0,0,1, 0,0,0,0,0,  0,6,1,1, 1,0,2, 0,0,0,0,0);
    add(0,0,0, 0,0,1, 0,0,0,0,0,  0,6,1,1, 1,0,1, 0,0,0,0,0);
    add(0,0,0, 0,0,1, 0,0,0,0,0,  0,6,1,1, 0,0,4, 0,1,0,0,0);
    add(0,0,0, 0,0,0, 0,0,0,0,0,  0,6,1,1, 0,0,4, 0,0,0,0,0);
    add(0,0,0, 0,0,1, 0,0,0,0,0,  0,6,1,1, 0,0,3, 0,0,0,0,0);
    add(0,0,0, 0,0,1, 0,0,0,0,0,  0,6,1,1, 0,0,2, 0,0,0,0,0);
    add(1,1,0, 0,0,0, 0,0,0,0,0,  0,6,1,1, 0,1,2, 0,0,0,0,0);
    add(0,0,0, 0,0,1, 0,0,0,0,0,  0,6,1,1, 0,1,1, 0,0,0,0,0);
    add(0,0,0, 1,0,1, 0,0,0,0,0,  1,0,0,0, 0,1,1, 0,0,0,0,0);
    add(0,0,0, 0,0,0, 1,1,0,0,0,  0,0,0,0, 1,0,4, 0,0,0,0,0);
    add(1,4,1, 0,0,0, 0,0,0,0,0,  0,0,0,0, 1,1,4, 0,0,0,0,0);
    add(0,0,0, 1,0,0, 0,0,0,0,0,  1,3,1,1, 1,1,4, 0,0,0,0,0);
    add(0,0,0, 0,0,0, 1,1,1,0,0,  0,3,1,1, 1,0,4, 0,0,1,0,1);
    add(1,2,0, 1,0,0, 0,0,0,0,0,  0,3,1,1, 1,0,4, 0,0,0,0,1);
    add(0,0,0, 0,1,0, 0,0,0,0,0,  0,3,1,1, 1,0,4, 0,0,0,0,0);
    add(1,5,0, 0,0,0, 0,0,0,0,0,  0,3,1,1, 1,1,4, 0,0,0,0,0);
    add(0,0,0, 1,0,0, 0,0,0,0,0,  1,4,0,1, 1,1,4, 0,0,0,0,0);
    add(0,0,0, 0,1,0, 0,0,0,0,0,  1,4,0,1, 1,1,4, 0,0,0,0,0);
    add(0,0,0, 0,0,0, 1,1,1,1,0,  0,4,0,1, 1,0,4, 0,0,0,1,1);
    add(0,0,0, 0,0,0, 0,0,0,0,0,  0,4,0,1, 0,0,4, 0,0,0,0,0);
    add(1,1,0, 0,0,0, 0,0,0,0,0,  0,4,0,1, 0,1,4, 0,0,0,0,0);
    add(0,0,0, 1,0,0, 0,0,0,0,0,  1,0,0,0, 0,1,4, 0,0,0,0,0);
    add(0,0,0, 0,0,0, 1,1,0,0,1,  0,0,0,0, 0,0,4, 0,0,0,0,1);
    add(0,0,0, 0,1,1, 0,0,0,0,0,  0,0,0,0, 1,0,4, 0,0,0,0,0);
    add(1,2,0, 0,0,0, 0,0,0,0,0,  0,0,0,0, 1,1,4, 0,0,0,0,0);
    add(0,0,0, 1,1,1, 0,0,0,0,0,  0,0,0,0, 0,0,4, 0,0,0,0,0);

    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    e = '{req: 0, col: 0, pop: 0, pl: 0, trn: 0, sv: 0, tl: TW'(TO),
          ill: 0, to: 0, s1: 0, s2: 0, go: 0};
    compare_outputs("reset", e);
    chk("reset sel_col", 32'(sel_col), 32'd0);
    chk("reset sel_pop", 32'(sel_pop), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      key_valid = vecs[i].kv; key_code = vecs[i].kc; key_pop = vecs[i].kp;
      submit = vecs[i].sub; new_game = vecs[i].ng; tick_en = vecs[i].tk;
      move_done = vecs[i].md; move_ok = vecs[i].ok; win = vecs[i].w;
      win_player = vecs[i].wp; draw = vecs[i].dr;
      exp_q.push_back(vecs[i].e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard vec%0d: got empty queue expected entry", i);
      end else begin
        compare_outputs($sformatf("vec%0d", i), exp_q.pop_front());
      end
    end

    // Reset asserted while the board handshake is outstanding.
    @(negedge clk);
    idle_inputs();
    key_valid = 1; key_code = 4'd6;
    @(negedge clk);
    idle_inputs();
    submit = 1;
    @(negedge clk);
    idle_inputs();
    waited = 0;
    while (!move_req && waited < 4) begin
      @(negedge clk);
      waited++;
    end
    chk("issue move_req before reset", 32'(move_req), 32'd1);
    chk("issue move_col before reset", 32'(move_col), 32'd5);
    #2;
    reset_n = 1'b0;
    #1;
    e = '{req: 0, col: 0, pop: 0, pl: 0, trn: 0, sv: 0, tl: TW'(TO),
          ill: 0, to: 0, s1: 0, s2: 0, go: 0};
    compare_outputs("midreset", e);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post reset move_req", 32'(move_req), 32'd0);
    chk("post reset turn", 32'(turn), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/turn_scheduler.md
Name: turn_scheduler

Overview:
Sequences play for the Connect-4 game. It owns whose turn it is. It collects a column selection and a drop/pop choice from the decoded keypad, and commits that selection to the board logic through a req/done handshake when submit is pressed. It enforces a per-turn timeout and emits one-cycle score pulses that drive the score counter. It sits between the keypad decoder, the debounced buttons, the board/win-check logic and the score counter, and runs in the 50 Hz game clock domain.

Parameters:
COLS, 7, number of board columns; legal key codes are 1..COLS.
TIMEOUT_TICKS, 1500, tick_en pulses allowed per turn (30 s at 50 Hz); 0 disables the timeout.
TW, 11, width of the turn timer; must satisfy 2^TW > TIMEOUT_TICKS.

Ports:
clk  in  1  game clock.
reset_n  in  1  asynchronous, active-low reset.
tick_en  in  1  one-cycle timer tick enable.
key_valid  in  1  one-cycle pulse: new keypad code available.
key_code  in  4  decoded keypad value.
key_pop  in  1  pop mode selected (sampled with key_valid).
submit  in  1  one-cycle debounced submit pulse.
new_game  in  1  one-cycle request to start a new game.
move_req  out  1  move request to the board, level signal.
move_col  out  3  zero-based column for the move.
move_pop  out  1  1 = pop, 0 = drop.
move_player  out  1  0 = player 1, 1 = player 2.
move_done  in  1  one-cycle: board finished the move.
move_ok  in  1  move was legal (valid with move_done).
win  in  1  move produced a win (valid with move_done).
win_player  in  1  winner, which may be the non-mover on a pop.
draw  in  1  board is full with no winner (valid with move_done).
turn  out  1  current player.
sel_valid  out  1  a selection is latched.
sel_col  out  3  latched zero-based column.
sel_pop  out  1  latched pop flag.
time_left  out  TW  remaining ticks in the current turn.
illegal  out  1  one-cycle pulse: board rejected the move.
timeout  out  1  one-cycle pulse: turn forfeited on timeout.
score_p1  out  1  one-cycle pulse: player 1 won.
score_p2  out  1  one-cycle pulse: player 2 won.
game_over  out  1  high in the GAME_OVER state.

Behaviour:
- Reset (async, reset_n=0):
  - state=SELECT, turn=0, start_player=0.
  - sel_valid=0, sel_col=0, sel_pop=0, time_left=TIMEOUT_TICKS, ng_pend=0.
  - All pulses, move_req and game_over are 0.
- All outputs are registered. There are three states: SELECT, ISSUE and GAME_OVER.
- SELECT:
  - key_valid with 1<=key_code<=COLS: sel_col=key_code-1, sel_pop=key_pop, sel_valid=1. Reselection overwrites. Any other code is ignored.
  - submit with sel_valid=1: go to ISSUE next cycle. move_req=1, move_col/move_pop/move_player are driven from sel_col/sel_pop/turn. key_valid in the same cycle is ignored.
  - submit with sel_valid=0 is ignored.
  - Timer: when tick_en=1 and TIMEOUT_TICKS!=0, time_left decrements. When a tick arrives with time_left==1, the turn is forfeited:
    - timeout pulses and turn toggles.
    - sel_valid=0 and time_left reloads.
    - If submit (with sel_valid) coincides with the expiring tick, submit wins and no timeout occurs.
  - The timer is frozen outside SELECT.
- ISSUE:
  - move_req and the move_* outputs are held stable until move_done. Keypad input, submit and tick_en are ignored.
  - On move_done, move_req drops the next cycle and sel_valid is cleared. The result is applied with this priority:
    1. !move_ok: illegal pulses; return to SELECT with the same turn; time_left is not reloaded.
    2. win: score_p1 or score_p2 pulses per win_player; go to GAME_OVER.
    3. draw: go to GAME_OVER with no score pulse.
    4. Otherwise: turn toggles, time_left reloads, return to SELECT.
- GAME_OVER:
  - game_over=1; all inputs except new_game are ignored.
- new_game:
  - In SELECT or GAME_OVER it takes effect in one cycle:
    - start_player toggles and turn = the new start_player.
    - sel_valid=0, time_left reloads, state goes to SELECT.
    - Pulses and game state are discarded.
  - In ISSUE it sets ng_pend. It is applied on the cycle after move_done, after that move's score pulse is emitted (no pulse is suppressed). ng_pend is then cleared.
  - new_game always overrides a coincident key_valid, submit or tick_en.
- Reset mid-handshake: move_req deasserts immediately. The board logic is reset by the same source.

Test Plan:
- Reset, key_valid code 3, submit -> next cycle move_req=1, move_col=2, move_pop=0, move_player=0. Hold until move_done with ok=1 -> move_req=0, turn=1, time_left=1500.
- key_valid codes 0, 8, 15 then submit -> sel_valid stays 0, move_req never asserts. Code 7 with pop=1, submit -> move_col=6, move_pop=1.
- move_done with move_ok=0 -> illegal one-cycle pulse, turn unchanged, state SELECT, sel_valid=0, time_left not reloaded.
- TIMEOUT_TICKS=4, four tick_en pulses -> timeout pulse, turn 0->1, time_left=4. Repeat with submit coincident with the 4th tick -> no timeout, move_req=1.
- Player 2 pops and move_done reports win=1, win_player=0 -> score_p1 pulses once, score_p2=0, game_over=1. Then new_game -> turn=1 (start_player toggled), game_over=0.
- new_game while move_req=1, then move_done with win=1 -> score pulse emitted, then new game starts the next cycle, ng_pend=0. Assert reset_n low during ISSUE -> move_req=0 asynchronously and all outputs at reset values.
